// File: rtl/rv32m_pkg.sv
// Shared RV32M types: funct3 encodings, mul/div unit FSM states, iteration count
// and operand-signedness helpers.
package rv32m;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } rv32m_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } rv32m_muldiv_state_t;

  localparam int RV32M_MULDIV_ITERATIONS = 32;

  function automatic logic rs1_is_signed(input rv32m_funct3_t op);
    return op inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic rs2_is_signed(input rv32m_funct3_t op);
    return op inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

  function automatic logic is_div_op(input rv32m_funct3_t op);
    return op[2];
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/rv32m_div_core.sv
// Iterative restoring divider on operand magnitudes: loads on start, performs one
// quotient bit per step, flags done after RV32M_MULDIV_ITERATIONS steps.
module rv32m_div_core
  import rv32m::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        dividend_signed,
  input  logic        divisor_signed,
  output logic [31:0] quot_mag,
  output logic [31:0] rem_mag,
  output logic        done
);

  logic [31:0] q_q;
  logic [31:0] r_q;
  logic [31:0] d_q;
  logic [5:0]  cnt_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  // q_q shifts dividend bits out at the top and quotient bits in at the bottom.
  assign shifted  = {r_q, q_q[31]};
  assign diff     = shifted - {1'b0, d_q};
  assign done     = (cnt_q == 6'(RV32M_MULDIV_ITERATIONS));
  assign quot_mag = q_q;
  assign rem_mag  = r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (start) begin
      q_q   <= magnitude(dividend, dividend_signed);
      d_q   <= magnitude(divisor, divisor_signed);
      r_q   <= '0;
      cnt_q <= '0;
    end else if (step && !done) begin
      if (!diff[32]) begin
        r_q <= diff[31:0];
        q_q <= {q_q[30:0], 1'b1};
      end else begin
        r_q <= shifted[31:0];
        q_q <= {q_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// RV32M multiply/divide unit: one command in flight, valid/ready on both sides.
// Define RV32M_MULDIV_FAST_MUL_EN for a single-cycle multiplier instead of shift-add.
module rv32m_muldiv_unit
  import rv32m::*;
#(
  parameter int ID_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [31:0]         cmd_rs1,
  input  logic [31:0]         cmd_rs2,
  input  logic [ID_WIDTH-1:0] cmd_id,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [31:0]         result_value,
  output logic [ID_WIDTH-1:0] result_id,
  output logic [1:0]          dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid, once raised, holds with its payload until that edge.

  rv32m_muldiv_state_t state_q, state_d;
  rv32m_funct3_t       op_in, op_q;

  logic                accept;
  logic                in_s1, in_s2;
  logic                div_zero, div_ovf, short_path;
  logic [31:0]         short_val;
  logic                mul_step, div_step, finish;

  logic                short_q;
  logic [31:0]         short_res_q;
  logic                neg_q, rem_neg_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [63:0]         prod_q, mcand_q;
  logic [31:0]         mplier_q;
  logic [5:0]          mul_cnt_q;
  logic [31:0]         result_q;
  logic [ID_WIDTH-1:0] result_id_q;

  logic [31:0]         quot_mag, rem_mag;
  logic                div_done;
  logic [63:0]         prod_fix;
  logic [31:0]         mul_val, quot_fix, rem_fix, div_val, final_val;

  assign op_in     = rv32m_funct3_t'(cmd_op);
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign in_s1     = rs1_is_signed(op_in);
  assign in_s2     = rs2_is_signed(op_in);

`ifdef RV32M_MULDIV_FAST_MUL_EN
  logic signed [32:0] fast_a, fast_b;
  logic signed [65:0] fast_p;
  assign fast_a = {in_s1 & cmd_rs1[31], cmd_rs1};
  assign fast_b = {in_s2 & cmd_rs2[31], cmd_rs2};
  assign fast_p = fast_a * fast_b;
`endif

  // Results that need no iteration are resolved at accept and finish one cycle later.
  always_comb begin
    short_val = '0;
    div_zero  = is_div_op(op_in) && (cmd_rs2 == 32'd0);
    div_ovf   = (op_in inside {F3_DIV, F3_REM}) && (cmd_rs1 == 32'h8000_0000) &&
                (cmd_rs2 == 32'hFFFF_FFFF);
    short_path = div_zero || div_ovf;
    if (div_zero) begin
      short_val = (op_in inside {F3_REM, F3_REMU}) ? cmd_rs1 : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      short_val = (op_in == F3_REM) ? 32'h0000_0000 : 32'h8000_0000;
    end
`ifdef RV32M_MULDIV_FAST_MUL_EN
    else if (!is_div_op(op_in)) begin
      short_val = (op_in == F3_MUL) ? fast_p[31:0] : fast_p[63:32];
    end
    short_path = short_path || !is_div_op(op_in);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mul_step = 1'b0;
    div_step = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (short_path || is_div_op(op_in)) ? DIV : MUL;
        end
      end
      MUL: begin
        if (mul_cnt_q == 6'(RV32M_MULDIV_ITERATIONS)) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          mul_step = 1'b1;
        end
      end
      DIV: begin
        if (short_q || div_done) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          div_step = 1'b1;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sign correction applied on the cycle that moves into DONE.
  always_comb begin
    prod_fix  = neg_q ? (~prod_q + 64'd1) : prod_q;
    mul_val   = (op_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    quot_fix  = neg_q ? (~quot_mag + 32'd1) : quot_mag;
    rem_fix   = rem_neg_q ? (~rem_mag + 32'd1) : rem_mag;
    div_val   = (op_q inside {F3_REM, F3_REMU}) ? rem_fix : quot_fix;
    final_val = short_q ? short_res_q : ((state_q == MUL) ? mul_val : div_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= F3_MUL;
      id_q        <= '0;
      short_q     <= 1'b0;
      short_res_q <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mul_cnt_q   <= '0;
      result_q    <= '0;
      result_id_q <= '0;
    end else begin
      if (accept) begin
        op_q        <= op_in;
        id_q        <= cmd_id;
        short_q     <= short_path;
        short_res_q <= short_val;
        neg_q       <= (in_s1 & cmd_rs1[31]) ^ (in_s2 & cmd_rs2[31]);
        rem_neg_q   <= in_s1 & cmd_rs1[31];
        prod_q      <= '0;
        mcand_q     <= {32'd0, magnitude(cmd_rs1, in_s1)};
        mplier_q    <= magnitude(cmd_rs2, in_s2);
        mul_cnt_q   <= '0;
      end
      if (mul_step) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q   <= {mcand_q[62:0], 1'b0};
        mplier_q  <= {1'b0, mplier_q[31:1]};
        mul_cnt_q <= mul_cnt_q + 6'd1;
      end
      if (finish) begin
        result_q    <= final_val;
        result_id_q <= id_q;
      end
    end
  end

  rv32m_div_core u_div_core (
    .clk             (clk),
    .rst             (rst),
    .start           (accept && is_div_op(op_in) && !short_path),
    .step            (div_step),
    .dividend        (cmd_rs1),
    .divisor         (cmd_rs2),
    .dividend_signed (in_s1),
    .divisor_signed  (in_s2),
    .quot_mag        (quot_mag),
    .rem_mag         (rem_mag),
    .done            (div_done)
  );

  assign result_valid = (state_q == DONE);
  assign result_value = result_q;
  assign result_id    = result_id_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit: hand-computed vectors, latency, stall and
// mid-operation reset, checked with immediate assertions.
module tb_rv32m_muldiv_unit;
  import rv32m::*;

  localparam int ID_W = 5;
`ifdef RV32M_MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif
  localparam int LAT_DIV   = 33;
  localparam int LAT_SHORT = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [31:0]     cmd_rs1, cmd_rs2;
  logic [ID_W-1:0] cmd_id;
  logic            result_valid;
  logic            result_ready;
  logic [31:0]     result_value;
  logic [ID_W-1:0] result_id;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  rv32m_muldiv_unit #(.ID_WIDTH(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_id       (cmd_id),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_value (result_value),
    .result_id    (result_id),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input rv32m_funct3_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [ID_W-1:0] id, input logic early_ready, input string tag);
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_rs1      = a;
    cmd_rs2      = b;
    cmd_id       = id;
    result_ready = early_ready;
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (!result_valid && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input rv32m_funct3_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [ID_W-1:0] id, input logic [31:0] exp_v,
                         input int exp_lat, input logic early_ready, input string tag);
    issue(op, a, b, id, early_ready, tag);
    wait_valid(exp_lat, tag);
    check({tag, "_value"}, result_value, exp_v);
    check({tag, "_id"}, 32'(result_id), 32'(id));
    release_result(tag);
  endtask

  // scoreboard-free directed sequence: expected values written inline
  initial begin
    int seen;
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = '0;
    cmd_rs1      = '0;
    cmd_rs2      = '0;
    cmd_id       = '0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_value", result_value, 32'd0);
    check("rst_id", 32'(result_id), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // multiply
    run_cmd(F3_MUL,    32'd7,         32'hFFFF_FFFD, 5'h11, 32'hFFFF_FFEB, LAT_MUL, 1'b0, "mul");
    run_cmd(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'h02, 32'h4000_0000, LAT_MUL, 1'b0, "mulh");
    run_cmd(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 32'hFFFF_FFFE, LAT_MUL, 1'b1, "mulhu");
    run_cmd(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'hFFFF_FFFF, LAT_MUL, 1'b0, "mulhsu");

    // iterative divide
    run_cmd(F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'h05, 32'hFFFF_FFFD, LAT_DIV, 1'b0, "div_neg");
    run_cmd(F3_REM,  32'hFFFF_FFF9, 32'd2, 5'h06, 32'hFFFF_FFFF, LAT_DIV, 1'b0, "rem_neg");
    run_cmd(F3_DIVU, 32'd100,       32'd7, 5'h07, 32'd14,        LAT_DIV, 1'b0, "divu");
    run_cmd(F3_REMU, 32'd100,       32'd7, 5'h08, 32'd2,         LAT_DIV, 1'b0, "remu");

    // short-path divide cases
    run_cmd(F3_DIV,  32'd5,         32'd0,         5'h09, 32'hFFFF_FFFF, LAT_SHORT, 1'b0, "div_by0");
    run_cmd(F3_REMU, 32'd5,         32'd0,         5'h0A, 32'd5,         LAT_SHORT, 1'b0, "remu_by0");
    run_cmd(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'h0B, 32'h8000_0000, LAT_SHORT, 1'b0, "div_ovf");
    run_cmd(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'h0C, 32'd0,         LAT_SHORT, 1'b0, "rem_ovf");

    // consumer stall with a competing command offered
    issue(F3_DIVU, 32'd100, 32'd7, 5'h15, 1'b0, "stall");
    wait_valid(LAT_DIV, "stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = F3_MUL;
      cmd_rs1   = 32'd3;
      cmd_rs2   = 32'd3;
      cmd_id    = 5'h01;
      @(posedge clk);
      #1;
      check("stall_valid", 32'(result_valid), 32'd1);
      check("stall_value", result_value, 32'd14);
      check("stall_id", 32'(result_id), 32'h15);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    release_result("stall");

    // reset at iteration 10 of a DIVU
    issue(F3_DIVU, 32'd1000, 32'd3, 5'h12, 1'b0, "abort");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    check("abort_value", result_value, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (result_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_cmd(F3_DIVU, 32'd1000, 32'd3, 5'h13, 32'd333, LAT_DIV, 1'b0, "after_abort");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
RV32M_MULDIV_UNIT -- requirements
Module: rv32m_muldiv_unit

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 5: width of the opaque tag passed from command to result.
REQ-002 SHALL have port clk  input  1: the only clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1: command offered.
REQ-005 SHALL have port cmd_ready  output  1: unit accepts command this cycle.
REQ-006 SHALL have port cmd_op  input  3: rv32m_funct3_t operation (MUL..REMU).
REQ-007 SHALL have port cmd_rs1  input  32: first operand (dividend / multiplicand).
REQ-008 SHALL have port cmd_rs2  input  32: second operand (divisor / multiplier).
REQ-009 SHALL have port cmd_id  input  ID_WIDTH: tag returned with result.
REQ-010 SHALL have port result_valid  output  1: result held and offered.
REQ-011 SHALL have port result_ready  input  1: consumer accepts result.
REQ-012 SHALL have port result_value  output  32: result word.
REQ-013 SHALL have port result_id  output  ID_WIDTH: tag of the command producing result_value.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, DONE; transfer = valid and ready high on the same edge.
REQ-015 SHALL drive cmd_ready high only in IDLE with rst low; one command in flight maximum.
REQ-016 SHALL on accept latch op, operands, id; MUL/MULH/MULHSU/MULHU -> MUL, DIV/DIVU/REM/REMU -> DIV, except special cases per REQ-019/020 -> DONE directly.
REQ-017 SHALL in MUL (iterative build) run 32 shift-add iterations on operand magnitudes into a 64-bit product, sign-correct per op (MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned), and return low word for MUL, high word otherwise; result_valid at accept edge N+33.
REQ-018 SHALL in DIV run 32 restoring-division iterations on magnitudes, then one sign-fix cycle (quotient negative iff operand signs differ, remainder takes dividend sign; signed ops only); result_valid at edge N+33.
REQ-019 SHALL for divisor zero return 0xFFFFFFFF for DIV/DIVU and rs1 for REM/REMU, result_valid at edge N+1.
REQ-020 SHALL for DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF return 0x80000000 (DIV) / 0x00000000 (REM), result_valid at edge N+1.
REQ-021 SHALL hold result_valid, result_value, result_id stable in DONE until result_ready high; then go IDLE on that edge.
REQ-022 SHALL ignore cmd_* inputs outside IDLE; next command earliest one cycle after result transfer.
REQ-023 SHALL treat result_ready high before result_valid as having no effect.

Reset
REQ-024 SHALL on rst high at an edge enter IDLE, abort any in-flight operation without emitting a result.
REQ-025 SHALL reset result_valid=0, result_value=0, result_id=0, all iteration counters and datapath registers =0; cmd_ready=0 while rst high.

Configuration
REQ-026 SHALL honour macro RV32M_MULDIV_FAST_MUL_EN: defined -> multiply ops computed with a single-cycle 33x33 signed multiplier, result_valid at edge N+1, MUL state unused; undefined -> iterative REQ-017 behaviour. Division unaffected either way.

Structure
REQ-027 SHALL place rv32m_muldiv_state_t (IDLE, MUL, DIV, DONE) and constant RV32M_MULDIV_ITERATIONS=32 in package rv32m, reusing rv32m_funct3_t.
REQ-028 SHALL isolate the iterative divider datapath (magnitude, restore step, counter) in sub-module rv32m_div_core; control FSM and multiply stay in rv32m_muldiv_unit.

Verification
REQ-029 SHALL cover MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB at N+33 (N+1 with RV32M_MULDIV_FAST_MUL_EN), id echoed.
REQ-030 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL cover DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2, all at N+33.
REQ-032 SHALL cover DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each at N+1.
REQ-033 SHALL cover result_ready low 10 cycles after result_valid -> value/id stable, cmd_ready 0; ready high -> cmd_ready 1 next cycle.
REQ-034 SHALL cover rst pulsed at iteration 10 of DIVU -> IDLE, result_valid 0, no result emitted; next command completes correctly.
